// File: rtl/mem_port_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Package     : mem_arb_pkg
// Description : FSM/grant encodings and the arbitration helper.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_IFETCH  = 2'd1;
  localparam arb_state_t ST_DACCESS = 2'd2;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  // Data wins when it is the only eligible requester, or on a tie when IF was served last.
  function automatic logic d_wins(input logic if_elig, input logic d_elig, input logic last_grant);
    return d_elig && (!if_elig || (last_grant == GNT_IF));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
//------------------------------------------------------------------------------
// Interface   : mem_port_arbiter_if
// Description : Pipeline-side and memory-side signals of the memory port arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              StallF;
  logic              MemReadM;
  logic              MemWriteM;
  logic [ADDR_W-1:0] ALUResultM;
  logic [DATA_W-1:0] WriteDataM;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              StallM;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ready;
  logic [CNT_W-1:0]  if_stall_cnt;
  logic [CNT_W-1:0]  d_stall_cnt;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, MemReadM, MemWriteM, ALUResultM, WriteDataM, m_rdata, m_ready,
    output if_rdata, if_valid, StallF, d_rdata, d_valid, StallM,
           m_req, m_we, m_addr, m_wdata, if_stall_cnt, d_stall_cnt
  );

  // Pipeline + memory view
  modport master (
    output if_req, if_addr, MemReadM, MemWriteM, ALUResultM, WriteDataM, m_rdata, m_ready,
    input  if_rdata, if_valid, StallF, d_rdata, d_valid, StallM,
           m_req, m_we, m_addr, m_wdata, if_stall_cnt, d_stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_perf_ctr.sv
//------------------------------------------------------------------------------
// Module      : mem_arb_perf_ctr
// Description : Saturating event counter with enable; sync active-low reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arb_perf_ctr #(
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_en,
  output logic      [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between IF and MEM stages with
//               alternating priority. Define MEM_ARB_PERF_EN for stall counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input wire logic         clk,
  input wire logic         rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic              r_last_grant;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;

  logic w_d_pend;
  logic w_grant_en;
  logic w_if_elig;
  logic w_d_elig;
  logic w_take_d;
  logic w_take_if;
  logic w_if_valid;
  logic w_d_valid;

  assign w_d_pend = bus.MemReadM | bus.MemWriteM;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Arbitration happens when idle or on the completing cycle; the requester
  // just served is excluded so a back-to-back grant always alternates.
  always_comb begin
    w_grant_en   = ((r_state != ST_IFETCH) && (r_state != ST_DACCESS)) || bus.m_ready;
    w_if_elig    = bus.if_req && w_grant_en && (r_state != ST_IFETCH);
    w_d_elig     = w_d_pend && w_grant_en && (r_state != ST_DACCESS);
    w_take_d     = d_wins(w_if_elig, w_d_elig, r_last_grant);
    w_take_if    = w_if_elig && !w_take_d;
    w_next_state = r_state;
    if (w_take_d) begin
      w_next_state = ST_DACCESS;
    end else if (w_take_if) begin
      w_next_state = ST_IFETCH;
    end else if (w_grant_en) begin
      w_next_state = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_grant <= GNT_IF;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
    end else if (w_take_d) begin
      r_last_grant <= GNT_D;
      r_addr       <= bus.ALUResultM;
      r_we         <= bus.MemWriteM;
      r_wdata      <= bus.WriteDataM;
    end else if (w_take_if) begin
      r_last_grant <= GNT_IF;
      r_addr       <= bus.if_addr;
      r_we         <= 1'b0;
    end
  end

  always_comb begin
    w_if_valid = (r_state == ST_IFETCH) && bus.m_ready;
    w_d_valid  = (r_state == ST_DACCESS) && bus.m_ready;
  end

  assign bus.m_req    = (r_state != ST_IDLE);
  assign bus.m_we     = r_we;
  assign bus.m_addr   = r_addr;
  assign bus.m_wdata  = r_wdata;
  assign bus.if_valid = w_if_valid;
  assign bus.d_valid  = w_d_valid;
  assign bus.if_rdata = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;
  assign bus.StallF   = bus.if_req && !w_if_valid;
  assign bus.StallM   = w_d_pend && !w_d_valid;

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf_ctr #(.CNT_W(CNT_W)) u_if_stall_ctr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (bus.StallF),
    .o_cnt (bus.if_stall_cnt)
  );

  mem_arb_perf_ctr #(.CNT_W(CNT_W)) u_d_stall_ctr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (bus.StallM),
    .o_cnt (bus.d_stall_cnt)
  );
`else
  assign bus.if_stall_cnt = '0;
  assign bus.d_stall_cnt  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_port_arbiter
// Description : Directed and random stimulus against a transaction-level model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  mem_port_arbiter_if bus_if ();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  // Reference model: one in-flight transaction record plus the last winner.
  bit          md_busy;
  bit          md_is_d;
  bit          md_last_d;
  logic [31:0] md_addr;
  bit          md_we;
  logic [31:0] md_wdata;
  logic [31:0] md_cnt_f;
  logic [31:0] md_cnt_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md_busy   = 1'b0;
    md_is_d   = 1'b0;
    md_last_d = 1'b0;
    md_addr   = '0;
    md_we     = 1'b0;
    md_wdata  = '0;
    md_cnt_f  = '0;
    md_cnt_d  = '0;
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step(input bit r, input bit ir, input logic [31:0] ia,
                      input bit rd, input bit wr, input logic [31:0] da,
                      input logic [31:0] wd, input bit rdy, input logic [31:0] rdat);
    bit exp_ifv, exp_dv, exp_sf, exp_sm, done, cand_if, cand_d, pick_d;
    @(negedge clk);
    rst                  = r;
    bus_if.if_req        = ir;
    bus_if.if_addr       = ia;
    bus_if.MemReadM      = rd;
    bus_if.MemWriteM     = wr;
    bus_if.ALUResultM    = da;
    bus_if.WriteDataM    = wd;
    bus_if.m_ready       = rdy;
    bus_if.m_rdata       = rdat;
    #1;
    exp_ifv = md_busy && !md_is_d && rdy;
    exp_dv  = md_busy && md_is_d && rdy;
    exp_sf  = ir && !exp_ifv;
    exp_sm  = (rd || wr) && !exp_dv;
    chk("m_req",    {63'd0, bus_if.m_req},    {63'd0, md_busy});
    chk("if_valid", {63'd0, bus_if.if_valid}, {63'd0, exp_ifv});
    chk("d_valid",  {63'd0, bus_if.d_valid},  {63'd0, exp_dv});
    chk("StallF",   {63'd0, bus_if.StallF},   {63'd0, exp_sf});
    chk("StallM",   {63'd0, bus_if.StallM},   {63'd0, exp_sm});
    chk("m_addr",   {32'd0, bus_if.m_addr},   {32'd0, md_addr});
    chk("m_we",     {63'd0, bus_if.m_we},     {63'd0, md_we});
    chk("m_wdata",  {32'd0, bus_if.m_wdata},  {32'd0, md_wdata});
    chk("if_rdata", {32'd0, bus_if.if_rdata}, {32'd0, rdat});
    chk("d_rdata",  {32'd0, bus_if.d_rdata},  {32'd0, rdat});
`ifdef MEM_ARB_PERF_EN
    chk("if_stall_cnt", {32'd0, bus_if.if_stall_cnt}, {32'd0, md_cnt_f});
    chk("d_stall_cnt",  {32'd0, bus_if.d_stall_cnt},  {32'd0, md_cnt_d});
`else
    chk("if_stall_cnt", {32'd0, bus_if.if_stall_cnt}, 64'd0);
    chk("d_stall_cnt",  {32'd0, bus_if.d_stall_cnt},  64'd0);
`endif
    if (!r) begin
      model_reset();
    end else begin
      if (exp_sf && md_cnt_f != 32'hFFFF_FFFF) md_cnt_f++;
      if (exp_sm && md_cnt_d != 32'hFFFF_FFFF) md_cnt_d++;
      done    = md_busy && rdy;
      cand_if = ir && !(done && !md_is_d);
      cand_d  = (rd || wr) && !(done && md_is_d);
      if (!md_busy || done) begin
        if (cand_if || cand_d) begin
          pick_d    = cand_d && (!cand_if || !md_last_d);
          md_busy   = 1'b1;
          md_is_d   = pick_d;
          md_last_d = pick_d;
          if (pick_d) begin
            md_addr  = da;
            md_we    = wr;
            md_wdata = wd;
          end else begin
            md_addr  = ia;
            md_we    = 1'b0;
          end
        end else begin
          md_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_reset();
    rst = 1'b0;
    bus_if.if_req = 1'b0; bus_if.if_addr = '0; bus_if.MemReadM = 1'b0;
    bus_if.MemWriteM = 1'b0; bus_if.ALUResultM = '0; bus_if.WriteDataM = '0;
    bus_if.m_ready = 1'b0; bus_if.m_rdata = '0;

    // Reset state (outputs checked against an all-zero model)
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Fetch only: ready arrives on the second m_req cycle
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h00500093);
    chk("fetch_valid", {63'd0, bus_if.if_valid}, 64'd1);
    chk("fetch_data",  {32'd0, bus_if.if_rdata}, 64'h00500093);
    step(1'b1, 1'b0, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Store only with immediate ready
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0);
    chk("store_we",    {63'd0, bus_if.m_we},    64'd1);
    chk("store_addr",  {32'd0, bus_if.m_addr},  64'h100);
    chk("store_wdata", {32'd0, bus_if.m_wdata}, 64'hDEADBEEF);
    chk("store_valid", {63'd0, bus_if.d_valid}, 64'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

    // Contention after reset and fairness: D, IF, D, IF, D, IF back-to-back
    do_reset();
    step(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h0);
      chk("fair_d_turn",  {63'd0, bus_if.d_valid},  (k % 2 == 0) ? 64'd1 : 64'd0);
      chk("fair_if_turn", {63'd0, bus_if.if_valid}, (k % 2 == 0) ? 64'd0 : 64'd1);
      chk("fair_no_idle", {63'd0, bus_if.m_req},    64'd1);
    end

    // Input change while waiting: address must hold
    do_reset();
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("hold_addr", {32'd0, bus_if.m_addr}, 64'h40);
    step(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    chk("hold_addr_done", {32'd0, bus_if.m_addr}, 64'h40);
    step(1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

    // Reset mid-transaction
    step(1'b1, 1'b1, 32'h60, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h60, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
    chk("abort_busy", {63'd0, bus_if.m_req}, 64'd1);
    step(1'b0, 1'b1, 32'h60, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h60, 1'b0, 1'b0, 32'h300, 32'h0, 1'b1, 32'h0);
    chk("abort_m_req",   {63'd0, bus_if.m_req},   64'd0);
    chk("abort_d_valid", {63'd0, bus_if.d_valid}, 64'd0);
    chk("abort_if_cnt",  {32'd0, bus_if.if_stall_cnt}, 64'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit rd_r, wr_r;
      rd_r = ($urandom_range(0, 99) < 35);
      wr_r = ($urandom_range(0, 99) < 25);
      step(($urandom_range(0, 99) >= 2),
           ($urandom_range(0, 99) < 65), $urandom,
           rd_r, wr_r, $urandom, $urandom,
           ($urandom_range(0, 99) < 50), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
